// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle: decode-side fields, execute-side copies, stall/flush controls.
// Latency: none (wiring only).
// Backpressure: stall_e/flush_e flow towards the register; stall_d flows back to decode.
interface id_ex_stage_reg_if #(
    parameter int XLEN = 32
);
    // Decode-stage inputs to the register
    logic            valid_d;
    logic [XLEN-1:0] pc_d, pc_plus4_d, rd1_d, rd2_d, imm_d;
    logic [4:0]      rs1_d, rs2_d, rd_d;
    logic            reg_write_d, mem_read_d, mem_write_d, mem_to_reg_d;
    logic            alu_src_d, branch_d, jump_d;
    logic [3:0]      alu_ctrl_d;

    // Pipeline control
    logic            flush_e;
    logic            stall_e;
    logic            stall_d;

    // Registered execute-stage copies
    logic            valid_e;
    logic [XLEN-1:0] pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e;
    logic [4:0]      rs1_e, rs2_e, rd_e;
    logic            reg_write_e, mem_read_e, mem_write_e, mem_to_reg_e;
    logic            alu_src_e, branch_e, jump_e;
    logic [3:0]      alu_ctrl_e;

    // Decode/hazard-control side
    modport master (
        output valid_d, pc_d, pc_plus4_d, rd1_d, rd2_d, imm_d, rs1_d, rs2_d, rd_d,
               reg_write_d, mem_read_d, mem_write_d, mem_to_reg_d, alu_src_d,
               branch_d, jump_d, alu_ctrl_d, flush_e, stall_e,
        input  stall_d, valid_e, pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e, rs1_e, rs2_e,
               rd_e, reg_write_e, mem_read_e, mem_write_e, mem_to_reg_e, alu_src_e,
               branch_e, jump_e, alu_ctrl_e
    );

    // Pipeline register side
    modport slave (
        input  valid_d, pc_d, pc_plus4_d, rd1_d, rd2_d, imm_d, rs1_d, rs2_d, rd_d,
               reg_write_d, mem_read_d, mem_write_d, mem_to_reg_d, alu_src_d,
               branch_d, jump_d, alu_ctrl_d, flush_e, stall_e,
        output stall_d, valid_e, pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e, rs1_e, rs2_e,
               rd_e, reg_write_e, mem_read_e, mem_write_e, mem_to_reg_e, alu_src_e,
               branch_e, jump_e, alu_ctrl_e
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Latency: 1 cycle decode->execute; stall_d is combinational from E state and D indices.
// Backpressure: flush_e > stall_e (hold) > load-use (bubble, decode held) > load.
// Optional: define ID_EX_PERF_CNT_EN for saturating bubble_cnt/flush_cnt outputs.
module id_ex_stage_reg #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    id_ex_stage_reg_if.slave    bus
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]         bubble_cnt,
    output logic [31:0]         flush_cnt
`endif
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            alu_src;
        logic            branch;
        logic            jump;
        logic [3:0]      alu_ctrl;
    } ex_t;

    ex_t  slot_in;
    ex_t  ex_d;
    ex_t  ex_q;
    logic load_use;

    // Gather the decode fields into one slot image
    always_comb begin
        slot_in            = '0;
        slot_in.valid      = bus.valid_d;
        slot_in.pc         = bus.pc_d;
        slot_in.pc_plus4   = bus.pc_plus4_d;
        slot_in.rd1        = bus.rd1_d;
        slot_in.rd2        = bus.rd2_d;
        slot_in.imm        = bus.imm_d;
        slot_in.rs1        = bus.rs1_d;
        slot_in.rs2        = bus.rs2_d;
        slot_in.rd         = bus.rd_d;
        slot_in.reg_write  = bus.reg_write_d;
        slot_in.mem_read   = bus.mem_read_d;
        slot_in.mem_write  = bus.mem_write_d;
        slot_in.mem_to_reg = bus.mem_to_reg_d;
        slot_in.alu_src    = bus.alu_src_d;
        slot_in.branch     = bus.branch_d;
        slot_in.jump       = bus.jump_d;
        slot_in.alu_ctrl   = bus.alu_ctrl_d;
    end

    // A load in E whose destination feeds the D instruction cannot forward in time
    assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & bus.valid_d &
                      ((ex_q.rd == bus.rs1_d) | (ex_q.rd == bus.rs2_d));

    // Redirect cancels any hold request: the held decode slot is being discarded anyway
    assign bus.stall_d = (load_use | bus.stall_e) & ~bus.flush_e;

    // Next-state selection in priority order: flush, hold, hazard bubble, load
    always_comb begin
        ex_d = ex_q;
        if (bus.flush_e) begin
            ex_d = '0;
        end else if (bus.stall_e) begin
            ex_d = ex_q;
        end else if (load_use) begin
            ex_d = '0;
        end else begin
            ex_d = slot_in;
            // An empty decode slot carries data but must never cause side effects
            if (!bus.valid_d) begin
                ex_d.reg_write  = 1'b0;
                ex_d.mem_read   = 1'b0;
                ex_d.mem_write  = 1'b0;
                ex_d.mem_to_reg = 1'b0;
                ex_d.alu_src    = 1'b0;
                ex_d.branch     = 1'b0;
                ex_d.jump       = 1'b0;
                ex_d.rd         = 5'd0;
            end
        end
    end

    // Execute-stage register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.valid_e      = ex_q.valid;
    assign bus.pc_e         = ex_q.pc;
    assign bus.pc_plus4_e   = ex_q.pc_plus4;
    assign bus.rd1_e        = ex_q.rd1;
    assign bus.rd2_e        = ex_q.rd2;
    assign bus.imm_e        = ex_q.imm;
    assign bus.rs1_e        = ex_q.rs1;
    assign bus.rs2_e        = ex_q.rs2;
    assign bus.rd_e         = ex_q.rd;
    assign bus.reg_write_e  = ex_q.reg_write;
    assign bus.mem_read_e   = ex_q.mem_read;
    assign bus.mem_write_e  = ex_q.mem_write;
    assign bus.mem_to_reg_e = ex_q.mem_to_reg;
    assign bus.alu_src_e    = ex_q.alu_src;
    assign bus.branch_e     = ex_q.branch;
    assign bus.jump_e       = ex_q.jump;
    assign bus.alu_ctrl_e   = ex_q.alu_ctrl;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] flush_cnt_q;
    logic        hazard_bubble;

    assign hazard_bubble = load_use & ~bus.flush_e & ~bus.stall_e;

    // Saturating event counters for hazard bubbles and flush bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= 32'd0;
            flush_cnt_q  <= 32'd0;
        end else begin
            if (hazard_bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
            if (bus.flush_e && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: driver pushes model expectations, monitor pops and compares.
// Latency: expects E copy one edge after each drive; stall_d checked mid-cycle.
// Backpressure: decode inputs are held whenever the model predicts stall_d.
module tb_id_ex_stage_reg;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_stage_reg_if #(.XLEN(XLEN)) bus ();

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt;
    logic [31:0] flush_cnt;
`endif

    id_ex_stage_reg #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc, pc_plus4, rd1, rd2, imm;
        logic [4:0]      rs1, rs2, rd;
        logic            reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump;
        logic [3:0]      alu_ctrl;
    } slot_t;

    typedef struct {
        bit          stall;
        slot_t       e;
        int unsigned bub;
        int unsigned fl;
    } exp_t;

    exp_t        sb_q[$];
    slot_t       m_e;
    int unsigned m_bub, m_fl;
    bit          last_stall;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic slot_t read_e();
        slot_t s;
        s.valid = bus.valid_e; s.pc = bus.pc_e; s.pc_plus4 = bus.pc_plus4_e;
        s.rd1 = bus.rd1_e; s.rd2 = bus.rd2_e; s.imm = bus.imm_e;
        s.rs1 = bus.rs1_e; s.rs2 = bus.rs2_e; s.rd = bus.rd_e;
        s.reg_write = bus.reg_write_e; s.mem_read = bus.mem_read_e;
        s.mem_write = bus.mem_write_e; s.mem_to_reg = bus.mem_to_reg_e;
        s.alu_src = bus.alu_src_e; s.branch = bus.branch_e; s.jump = bus.jump_e;
        s.alu_ctrl = bus.alu_ctrl_e;
        return s;
    endfunction

    function automatic slot_t rand_d();
        slot_t s;
        s.valid      = ($urandom % 4) != 0;
        s.pc         = $urandom; s.pc_plus4 = $urandom;
        s.rd1        = $urandom; s.rd2 = $urandom; s.imm = $urandom;
        s.rs1        = 5'($urandom_range(0, 3));
        s.rs2        = 5'($urandom_range(0, 3));
        s.rd         = 5'($urandom_range(0, 3));
        s.reg_write  = 1'($urandom); s.mem_read = 1'($urandom);
        s.mem_write  = 1'($urandom); s.mem_to_reg = 1'($urandom);
        s.alu_src    = 1'($urandom); s.branch = 1'($urandom); s.jump = 1'($urandom);
        s.alu_ctrl   = 4'($urandom);
        return s;
    endfunction

    // Reading of the hazard rule: a valid load in E writing a non-zero register read by a valid D
    function automatic bit needs_load_result(input slot_t e, input slot_t d);
        if (!(e.valid && e.mem_read && d.valid) || e.rd == 0) return 1'b0;
        return (d.rs1 == e.rd) || (d.rs2 == e.rd);
    endfunction

    task automatic drive(input slot_t d, input bit fl, input bit st);
        exp_t r;
        bit   hz;
        bus.valid_d = d.valid; bus.pc_d = d.pc; bus.pc_plus4_d = d.pc_plus4;
        bus.rd1_d = d.rd1; bus.rd2_d = d.rd2; bus.imm_d = d.imm;
        bus.rs1_d = d.rs1; bus.rs2_d = d.rs2; bus.rd_d = d.rd;
        bus.reg_write_d = d.reg_write; bus.mem_read_d = d.mem_read;
        bus.mem_write_d = d.mem_write; bus.mem_to_reg_d = d.mem_to_reg;
        bus.alu_src_d = d.alu_src; bus.branch_d = d.branch; bus.jump_d = d.jump;
        bus.alu_ctrl_d = d.alu_ctrl;
        bus.flush_e = fl; bus.stall_e = st;
        hz      = needs_load_result(m_e, d);
        r.stall = (hz || st) && !fl;
        if (fl) begin
            m_e = '0;
            if (m_fl != 32'hFFFF_FFFF) m_fl++;
        end else if (st) begin
            // execute stage frozen
        end else if (hz) begin
            m_e = '0;
            if (m_bub != 32'hFFFF_FFFF) m_bub++;
        end else if (d.valid) begin
            m_e = d;
        end else begin
            m_e = d;
            {m_e.reg_write, m_e.mem_read, m_e.mem_write, m_e.mem_to_reg,
             m_e.alu_src, m_e.branch, m_e.jump} = '0;
            m_e.rd = 5'd0;
        end
        r.e = m_e; r.bub = m_bub; r.fl = m_fl;
        sb_q.push_back(r);
        last_stall = r.stall;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Mid-cycle: the combinational stall must match this cycle's expectation
    always @(negedge clk) begin
        if (rst_n && sb_q.size() > 0) chk("stall_d", 64'(bus.stall_d), 64'(sb_q[0].stall));
    end

    // Just after the edge: the registered copy must match the model
    always @(posedge clk) begin
        exp_t r;
        #1;
        if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            n_checks++;
            if (read_e() !== r.e) begin
                n_fail++;
                $display("FAIL e_slot: got %h expected %h", read_e(), r.e);
            end
`ifdef ID_EX_PERF_CNT_EN
            chk("bubble_cnt", 64'(bubble_cnt), 64'(r.bub));
            chk("flush_cnt", 64'(flush_cnt), 64'(r.fl));
`endif
        end
    end

    initial begin
        slot_t d, d2, held;
        bit    fl, st;
        rst_n = 1'b0;
        m_e = '0; m_bub = 0; m_fl = 0; last_stall = 1'b0;
        drive_idle();
        #3;
        chk("reset_e_zero", 64'(read_e() == '0), 64'd1);
        chk("reset_stall_d", 64'(bus.stall_d), 64'd0);
        bus.stall_e = 1'b1;
        #1;
        chk("reset_stall_d_stall_e", 64'(bus.stall_d), 64'd1);
        bus.stall_e = 1'b0;
`ifdef ID_EX_PERF_CNT_EN
        chk("reset_cnt", 64'({bubble_cnt, flush_cnt}), 64'd0);
`endif
        sb_q.delete();
        m_e = '0; m_bub = 0; m_fl = 0;
        tick(); tick();
        rst_n = 1'b1;

        // Normal flow
        d = '0; d.valid = 1; d.pc = 32'h100; d.rd1 = 32'h1234_5678; d.rd = 5'd5; d.reg_write = 1;
        drive(d, 0, 0); tick();
        chk("nf_pc", 64'(bus.pc_e), 64'h100);
        chk("nf_rd1", 64'(bus.rd1_e), 64'h1234_5678);
        chk("nf_rd_valid", 64'({bus.rd_e, bus.valid_e, bus.reg_write_e}), 64'({5'd5, 2'b11}));

        // Load-use: lw x7 then consumer of x7
        d = '0; d.valid = 1; d.rd = 5'd7; d.mem_read = 1; d.reg_write = 1;
        drive(d, 0, 0); tick();
        d2 = '0; d2.valid = 1; d2.rs2 = 5'd7; d2.rd = 5'd9; d2.pc = 32'h204;
        drive(d2, 0, 0); #1;
        chk("lu_stall", 64'(bus.stall_d), 64'd1);
        tick();
        chk("lu_bubble", 64'({bus.valid_e, bus.rd_e}), 64'd0);
        drive(d2, 0, 0); #1;
        chk("lu_release", 64'(bus.stall_d), 64'd0);
        tick();
        chk("lu_loaded", 64'({bus.valid_e, bus.rs2_e, bus.pc_e}), 64'({1'b1, 5'd7, 32'h204}));

        // Load into x0 never stalls
        d = '0; d.valid = 1; d.rd = 5'd0; d.mem_read = 1; d.reg_write = 1;
        drive(d, 0, 0); tick();
        chk("x0_rw_kept", 64'(bus.reg_write_e), 64'd1);
        d2 = '0; d2.valid = 1; d2.rs1 = 5'd0; d2.pc = 32'h300;
        drive(d2, 0, 0); #1;
        chk("x0_no_stall", 64'(bus.stall_d), 64'd0);
        tick();
        chk("x0_loaded", 64'(bus.pc_e), 64'h300);

        // Flush wins over stall
        d = rand_d(); d.valid = 1; d.reg_write = 1;
        drive(d, 0, 0); tick();
        drive(rand_d(), 1, 1); #1;
        chk("fl_stall_d", 64'(bus.stall_d), 64'd0);
        tick();
        chk("fl_bubble", 64'(read_e() == '0), 64'd1);
`ifdef ID_EX_PERF_CNT_EN
        chk("fl_cnt", 64'(flush_cnt), 64'd1);
`endif

        // Hold for three cycles with changing decode inputs
        d = rand_d(); d.valid = 1;
        drive(d, 0, 0); tick();
        held = read_e();
        for (int i = 0; i < 3; i++) begin
            drive(rand_d(), 0, 1); #1;
            chk("hold_stall_d", 64'(bus.stall_d), 64'd1);
            tick();
            chk("hold_e", 64'(read_e() == held), 64'd1);
        end

        // Randomized traffic; decode holds its instruction whenever stalled
        d = rand_d();
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) d = rand_d();
            fl = ($urandom % 8) == 0;
            st = ($urandom % 6) == 0;
            drive(d, fl, st);
            tick();
        end

        // Asynchronous reset mid-operation
        d = rand_d(); d.valid = 1; d.reg_write = 1;
        drive(d, 0, 0); tick();
        rst_n = 1'b0;
        #1;
        chk("arst_valid_rw", 64'({bus.valid_e, bus.reg_write_e}), 64'd0);
`ifdef ID_EX_PERF_CNT_EN
        chk("arst_cnt", 64'({bubble_cnt, flush_cnt}), 64'd0);
`endif
        sb_q.delete();
        m_e = '0; m_bub = 0; m_fl = 0; last_stall = 1'b0;
        tick();
        rst_n = 1'b1;
        d = rand_d(); d.valid = 1;
        drive(d, 0, 0); tick();
        chk("post_reset_load", 64'(bus.pc_e), 64'(d.pc));
        for (int i = 0; i < 5; i++) begin
            if (!last_stall) d = rand_d();
            drive(d, 0, 0);
            tick();
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic drive_idle();
        bus.valid_d = 0; bus.pc_d = '0; bus.pc_plus4_d = '0; bus.rd1_d = '0;
        bus.rd2_d = '0; bus.imm_d = '0; bus.rs1_d = '0; bus.rs2_d = '0; bus.rd_d = '0;
        bus.reg_write_d = 0; bus.mem_read_d = 0; bus.mem_write_d = 0;
        bus.mem_to_reg_d = 0; bus.alu_src_d = 0; bus.branch_d = 0; bus.jump_d = 0;
        bus.alu_ctrl_d = '0; bus.flush_e = 0; bus.stall_e = 0;
    endtask

endmodule

// File: doc/id_ex_stage_reg.md
ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 Parameter XLEN, default 32, datapath width of PC, operand and immediate fields.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 valid_d  input  1  decode slot holds a real instruction.
REQ-005 pc_d, pc_plus4_d, rd1_d, rd2_d, imm_d  input  XLEN each  decode PC, PC+4, register-file read data 1/2, immediate.
REQ-006 rs1_d, rs2_d, rd_d  input  5 each  source/destination register indices.
REQ-007 reg_write_d, mem_read_d, mem_write_d, mem_to_reg_d, alu_src_d, branch_d, jump_d  input  1 each  decode control bits.
REQ-008 alu_ctrl_d  input  4  ALU operation select.
REQ-009 flush_e  input  1  branch/jump redirect from execute; kill incoming instruction.
REQ-010 stall_e  input  1  downstream hold; execute register must not change.
REQ-011 stall_d  output  1  combinational: fetch and decode must hold this cycle.
REQ-012 valid_e plus every *_d field above renamed *_e  output  same widths  registered execute-stage copy.

Function
REQ-013 Load-use hazard SHALL be: valid_e & mem_read_e & (rd_e != 0) & valid_d & ((rd_e == rs1_d) | (rd_e == rs2_d)).
REQ-014 stall_d SHALL equal (load-use hazard | stall_e) & ~flush_e.
REQ-015 Update priority each rising edge SHALL be: flush_e > stall_e > load-use hazard > normal load.
REQ-016 flush_e=1: insert bubble regardless of stall_e.
REQ-017 stall_e=1 (no flush): all *_e outputs hold their values.
REQ-018 Load-use hazard (no flush, no stall_e): insert bubble; decode holds, so the same instruction loads on the following edge with the hazard cleared.
REQ-019 Normal load: every *_e register takes its *_d input; valid_e <= valid_d.
REQ-020 Bubble SHALL set valid_e, reg_write_e, mem_read_e, mem_write_e, branch_e, jump_e to 0 and rd_e to 0; remaining data fields SHALL be set to 0.
REQ-021 valid_d=0 with normal load SHALL load the slot with all control bits forced as in a bubble (no side effects from invalid slots).
REQ-022 Latency: one cycle from *_d to *_e; no combinational path from *_d to *_e.
REQ-023 rd_d = 0 with reg_write_d=1 SHALL propagate reg_write_e=1; x0 write suppression is downstream.

Reset
REQ-024 rst_n low SHALL asynchronously clear all *_e registers to 0, including valid_e.
REQ-025 Deassertion SHALL take effect on the next rising edge; first post-reset edge performs a normal update.
REQ-026 During reset stall_d SHALL be 0 (valid_e=0 removes the hazard term) unless stall_e=1.

Configuration
REQ-027 Macro ID_EX_PERF_CNT_EN defined: add outputs bubble_cnt and flush_cnt, 32 bits each, counting edges where REQ-018 and REQ-016 bubbles occur, saturating at 0xFFFFFFFF, cleared by rst_n.
REQ-028 Macro undefined: counter ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 Normal flow: valid_d=1, pc_d=0x100, rd1_d=0x12345678, rd_d=5, reg_write_d=1 -> next edge pc_e=0x100, rd1_e=0x12345678, rd_e=5, valid_e=1, stall_d=0.
REQ-030 Load-use: E holds lw rd=7 (mem_read_e=1), D has rs2_d=7 -> stall_d=1, next edge bubble (valid_e=0, rd_e=0); following edge D instruction loads, stall_d=0.
REQ-031 Hazard with rd_e=0: mem_read_e=1, rd_e=0, rs1_d=0 -> stall_d=0, normal load.
REQ-032 Flush over stall: flush_e=1 and stall_e=1 with valid E contents -> next edge bubble, stall_d=0; with ID_EX_PERF_CNT_EN flush_cnt increments by 1.
REQ-033 Hold: stall_e=1 for 3 cycles, *_d changing -> *_e unchanged for 3 edges, stall_d=1 throughout.
REQ-034 Reset mid-operation: rst_n low between edges with valid_e=1, reg_write_e=1 -> both 0 immediately, before next clk edge; counters read 0.
